// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Shares one streaming output bus among NUM_REQ requesters. A requester raises
// req with a burst length on req_numSteps; the arbiter picks a winner while
// idle, pulses req_start for it and then forwards exactly that many words from
// the owner to the output with no added latency. A zero-length grant
// consumes the request without entering BURST.
//
// Configuration macro:
//   BUS_ARBITER_ROUNDROBIN_EN  defined   -> round-robin, search starts one past
//                                           the last winner
//                              undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst             in   asynchronous reset, active low
//   req             in   [NUM_REQ]        burst request (level)
//   req_numSteps    in   [NUM_REQ*CNT_W]  burst length per requester
//   req_start       out  [NUM_REQ]        one-hot grant pulse
//   in_data         in   [NUM_REQ*W]      data per requester
//   in_isReady      in   [NUM_REQ]        requester offers a word
//   in_canReceive   out  [NUM_REQ]        arbiter accepts a word
//   out_data        out  [W]              forwarded word
//   out_isReady     out                   word valid towards downstream
//   out_canReceive  in                    downstream can accept
//   out_isLast      out                   final word of the burst
//   busy            out                   burst in progress
//   owner           out  [$clog2(NUM_REQ)] current/last granted requester
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 64,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CNT_W-1:0]     req_numSteps,
    output logic [NUM_REQ-1:0]           req_start,
    input  logic [NUM_REQ*W-1:0]         in_data,
    input  logic [NUM_REQ-1:0]           in_isReady,
    output logic [NUM_REQ-1:0]           in_canReceive,
    output logic [W-1:0]                 out_data,
    output logic                         out_isReady,
    input  logic                         out_canReceive,
    output logic                         out_isLast,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   owner
);

    localparam int OW = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OW-1:0]     owner_q, owner_d;
`ifdef BUS_ARBITER_ROUNDROBIN_EN
    logic [OW-1:0]     ptr_q, ptr_d;
`endif

    logic [OW-1:0]     win;
    logic [CNT_W-1:0]  win_steps;
    logic [W-1:0]      sel_data;
    logic              sel_ready;
    logic              can_rx;
    logic              xfer;

    // Winner selection. Loops run from lowest to highest priority so that the
    // last match written is the highest-priority requester.
    always_comb begin
        win = '0;
`ifdef BUS_ARBITER_ROUNDROBIN_EN
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [OW-1:0] idx;
            idx = OW'((int'(ptr_q) + k) % NUM_REQ);
            if (req[idx]) begin
                win = idx;
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[OW'(i)]) begin
                win = OW'(i);
            end
        end
`endif
    end

    // Slice muxes for the winner's burst length and the owner's data lane.
    always_comb begin
        win_steps = '0;
        sel_data  = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == OW'(i)) begin
                win_steps = req_numSteps[i*CNT_W +: CNT_W];
            end
            if (owner_q == OW'(i)) begin
                sel_data  = in_data[i*W +: W];
                sel_ready = in_isReady[OW'(i)];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
`ifdef BUS_ARBITER_ROUNDROBIN_EN
        ptr_d         = ptr_q;
`endif
        req_start     = '0;
        in_canReceive = '0;
        out_isReady   = 1'b0;
        out_isLast    = 1'b0;
        out_data      = '0;
        can_rx        = 1'b0;
        xfer          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // rst gating keeps the combinational grant silent while the
                // asynchronous reset is held.
                if (rst && (req != '0)) begin
                    req_start[win] = 1'b1;
                    owner_d        = win;
                    cnt_d          = win_steps;
`ifdef BUS_ARBITER_ROUNDROBIN_EN
                    ptr_d          = win;
`endif
                    if (win_steps != '0) begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                can_rx                 = out_canReceive && (cnt_q != '0);
                in_canReceive[owner_q] = can_rx;
                xfer                   = can_rx && sel_ready;
                out_isReady            = xfer;
                out_isLast             = xfer && (cnt_q == CNT_W'(1));
                // Data is zeroed between transfers so it never carries X.
                out_data               = xfer ? sel_data : '0;
                if (xfer) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
`ifdef BUS_ARBITER_ROUNDROBIN_EN
            ptr_q   <= OW'(NUM_REQ - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
`ifdef BUS_ARBITER_ROUNDROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign busy  = (state_q == ST_BURST);
    assign owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*CW-1:0] req_numSteps;
    logic [N-1:0]    req_start;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_isReady;
    logic [N-1:0]    in_canReceive;
    logic [W-1:0]    out_data;
    logic            out_isReady;
    logic            out_canReceive;
    logic            out_isLast;
    logic            busy;
    logic [1:0]      owner;

    bus_arbiter #(.NUM_REQ(N), .W(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_numSteps   (req_numSteps),
        .req_start      (req_start),
        .in_data        (in_data),
        .in_isReady     (in_isReady),
        .in_canReceive  (in_canReceive),
        .out_data       (out_data),
        .out_isReady    (out_isReady),
        .out_canReceive (out_canReceive),
        .out_isLast     (out_isLast),
        .busy           (busy),
        .owner          (owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding burst described by owner and words left.
    bit m_busy;
    int m_owner, m_rem, m_ptr;

    bit auto_drop;
    int n_xfer, n_last, n_busy, cyc;
    int gq[$];
    int gc[$];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_start;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
`ifdef BUS_ARBITER_ROUNDROBIN_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic set_steps(input int i, input int n);
        req_numSteps[i*CW +: CW] = CW'(n);
    endtask

    // One clock cycle: compare at negedge, advance model at posedge, return
    // at posedge+1 so the caller may drive the next cycle's inputs.
    task automatic cycle(input bit use_exp = 1'b0, input logic [N-1:0] exp_start = '0);
        logic [N-1:0] e_start, e_can;
        bit e_rdy, e_last, x;
        int w, ns;
        @(negedge clk);
        e_start = '0; e_can = '0; e_rdy = 0; e_last = 0; x = 0; w = -1;
        if (rst) begin
            if (!m_busy) begin
                w = pick(req);
                if (w >= 0) e_start[w] = 1'b1;
            end else begin
                if (out_canReceive && m_rem > 0) e_can[m_owner] = 1'b1;
                x      = e_can[m_owner] && in_isReady[m_owner];
                e_rdy  = x;
                e_last = x && (m_rem == 1);
            end
        end
        chk("req_start", req_start, e_start);
        chk("in_canReceive", in_canReceive, e_can);
        chk("out_isReady", out_isReady, e_rdy);
        chk("out_isLast", out_isLast, e_last);
        chk("busy", busy, rst && m_busy);
        chk("owner", owner, rst ? m_owner : 0);
        if (e_rdy) chk("out_data", out_data, in_data[m_owner*W +: W]);
        if (use_exp) chk("tbl_start", req_start, exp_start);
        for (int i = 0; i < N; i++) begin
            if (req_start[i]) begin
                gq.push_back(i);
                gc.push_back(cyc);
            end
        end
        if (out_isReady) n_xfer++;
        if (out_isLast) n_last++;
        if (busy) n_busy++;
        @(posedge clk);
        if (!rst) begin
            m_busy = 0; m_rem = 0; m_owner = 0; m_ptr = N - 1;
        end else if (!m_busy) begin
            if (w >= 0) begin
                ns      = int'(req_numSteps[w*CW +: CW]);
                m_owner = w;
                m_ptr   = w;
                m_rem   = ns;
                m_busy  = (ns != 0);
            end
        end else if (x) begin
            m_rem--;
            if (m_rem == 0) m_busy = 0;
        end
        cyc++;
        #1;
        if (auto_drop && w >= 0) req[w] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        cycle();
        rst = 1'b1;
        n_xfer = 0; n_last = 0; n_busy = 0;
        gq.delete(); gc.delete();
    endtask

    initial begin
        int exp_order[5];
        logic [3:0] pat;

        rst = 1'b1; req = '0; req_numSteps = '0; in_data = '0;
        in_isReady = '0; out_canReceive = 1'b0; auto_drop = 0;
        m_busy = 0; m_rem = 0; m_owner = 0; m_ptr = N - 1; cyc = 0;
        n_xfer = 0; n_last = 0; n_busy = 0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};

        // Reset state, with requests pending that must not be granted.
        #2 rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_steps(i, 3);
        out_canReceive = 1'b1;
        in_isReady = 4'b1111;
        #1;
        chk("rst_data_notx", $isunknown(out_data), 0);
        chk("rst_start", req_start, 0);
        cycle();
        cycle();
        rst = 1'b1;
        req = '0;

        // Arbitration table using zero-length grants (stays in IDLE).
`ifdef BUS_ARBITER_ROUNDROBIN_EN
        tbl[0] = '{4'b0000, 4'b0000};
        tbl[1] = '{4'b1010, 4'b0010};
        tbl[2] = '{4'b1100, 4'b0100};
        tbl[3] = '{4'b1000, 4'b1000};
        tbl[4] = '{4'b1111, 4'b0001};
        tbl[5] = '{4'b1111, 4'b0010};
        tbl[6] = '{4'b0001, 4'b0001};
        exp_order = '{0, 1, 2, 3, 0};
`else
        tbl[0] = '{4'b0000, 4'b0000};
        tbl[1] = '{4'b1010, 4'b0010};
        tbl[2] = '{4'b1100, 4'b0100};
        tbl[3] = '{4'b1000, 4'b1000};
        tbl[4] = '{4'b1111, 4'b0001};
        tbl[5] = '{4'b1111, 4'b0001};
        tbl[6] = '{4'b0001, 4'b0001};
        exp_order = '{0, 0, 0, 0, 0};
`endif
        req_numSteps = '0;
        for (int i = 0; i < 7; i++) begin
            req = tbl[i].req;
            cycle(1'b1, tbl[i].exp_start);
        end
        req = '0;

        // Single burst of three words from requester 2.
        do_reset();
        auto_drop = 1;
        for (int i = 0; i < N; i++) set_steps(i, 3);
        out_canReceive = 1'b1; in_isReady = 4'b1111;
        req = 4'b0100;
        for (int i = 0; i < 5; i++) cycle();
        chk("single_words", n_xfer, 3);
        chk("single_last", n_last, 1);
        chk("single_busy", n_busy, 3);
        chk("single_owner", owner, 2);
        chk("single_grants", gq.size(), 1);

        // Contention with all requests held, one word each.
        do_reset();
        auto_drop = 0;
        for (int i = 0; i < N; i++) set_steps(i, 1);
        req = 4'b1111;
        for (int i = 0; i < 10; i++) cycle();
        chk("cont_count", gq.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) begin
                chk("cont_order", gq[k], exp_order[k]);
                if (k > 0) chk("cont_gap", gc[k] - gc[k-1], 2);
            end
        end
        req = '0;

        // Backpressure: downstream ready follows 1,0,0,1 repeating.
        do_reset();
        auto_drop = 1;
        set_steps(0, 4);
        req = 4'b0001;
        pat = 4'b1001;
        for (int i = 0; i < 12; i++) begin
            out_canReceive = pat[i % 4];
            cycle();
        end
        chk("bp_words", n_xfer, 4);
        chk("bp_last", n_last, 1);
        out_canReceive = 1'b1;

        // Zero-length grant followed immediately by a real one.
        do_reset();
        set_steps(1, 0);
        set_steps(3, 2);
        req = 4'b0010;
        cycle();
        chk("zl_busy", busy, 0);
        req = 4'b1000;
        for (int i = 0; i < 4; i++) cycle();
        chk("zl_grants", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("zl_first", gq[0], 1);
            chk("zl_second", gq[1], 3);
            chk("zl_gap", gc[1] - gc[0], 1);
        end
        chk("zl_words", n_xfer, 2);

        // Reset in the middle of a five-word burst.
        do_reset();
        set_steps(0, 5);
        req = 4'b0001;
        for (int i = 0; i < 3; i++) cycle();
        chk("mid_words", n_xfer, 2);
        req = 4'b0001;
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_can", in_canReceive, 0);
        chk("mid_rdy", out_isReady, 0);
        chk("mid_last", out_isLast, 0);
        chk("mid_start", req_start, 0);
        cycle();
        chk("mid_nolast", n_last, 0);
        rst = 1'b1;
        set_steps(0, 1);
        n_xfer = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("post_words", n_xfer, 1);
        chk("post_last", n_last, 1);
        chk("post_owner", owner, 0);

        // Randomized traffic against the reference model.
        do_reset();
        auto_drop = 1;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 4 == 0)) begin
                    req[i] = 1'b1;
                    set_steps(i, int'($urandom % 6));
                end else if (req[i] && ($urandom % 16 == 0)) begin
                    req[i] = 1'b0;
                end
                in_data[i*W +: W] = {$urandom, $urandom};
            end
            in_isReady     = N'($urandom);
            out_canReceive = ($urandom % 4) != 0;
            rst            = ($urandom % 150) != 0;
            cycle();
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the output bus (2..8).
REQ-002 Parameter W, default 64, data word width.
REQ-003 Parameter CNT_W, default 8, burst length counter width.
REQ-004 Port clk  in  1  sole clock; all state on rising edge.
REQ-005 Port rst  in  1  asynchronous active-low reset (0 = reset asserted).
REQ-006 Port req  in  NUM_REQ  per-requester burst request, level, held until started.
REQ-007 Port req_numSteps  in  NUM_REQ*CNT_W  per-requester burst length in words, slice i at [i*CNT_W +: CNT_W].
REQ-008 Port req_start  out  NUM_REQ  one-hot grant pulse; request consumed in that cycle.
REQ-009 Port in_data  in  NUM_REQ*W  per-requester data, slice i at [i*W +: W].
REQ-010 Port in_isReady  in  NUM_REQ  word transfer; legal only while matching in_canReceive is 1.
REQ-011 Port in_canReceive  out  NUM_REQ  arbiter accepts a word from requester i this cycle.
REQ-012 Port out_data  out  W  forwarded word.
REQ-013 Port out_isReady  out  1  word transfer to downstream.
REQ-014 Port out_canReceive  in  1  downstream can accept a word.
REQ-015 Port out_isLast  out  1  high with out_isReady on the final word of a burst.
REQ-016 Port busy  out  1  burst in progress (state BURST).
REQ-017 Port owner  out  $clog2(NUM_REQ)  index of current/last granted requester.

Function
REQ-018 States: IDLE, BURST; encoding free.
REQ-019 In IDLE with any req bit set, winner chosen combinationally, req_start[winner]=1 that same cycle, counter loaded with req_numSteps[winner], owner updated, next state BURST.
REQ-020 Granted numSteps==0: req_start still pulses, no transfer, state stays IDLE, priority pointer still advances.
REQ-021 In IDLE: req_start only as per REQ-019/020, all in_canReceive 0, out_isReady 0.
REQ-022 In BURST: in_canReceive[owner] = out_canReceive & (counter!=0); all other in_canReceive 0; req_start all 0.
REQ-023 In BURST: out_data = in_data[owner] combinationally, out_isReady = in_isReady[owner] & in_canReceive[owner]; zero added latency.
REQ-024 Each transfer decrements counter by 1; no transfer, no change; out_canReceive low stalls indefinitely without loss.
REQ-025 out_isLast = out_isReady & (counter==1).
REQ-026 Transfer with counter==1: next state IDLE; new grant possible in the following cycle (one-cycle bubble between bursts).
REQ-027 Requests arriving or dropping during BURST ignored until IDLE; req deasserted before start is never granted.
REQ-028 out_data when out_isReady is 0 is don't-care but shall not be X after reset.

Reset
REQ-029 rst low asynchronously forces: state IDLE, counter 0, owner 0, priority pointer NUM_REQ-1; outputs req_start 0, in_canReceive 0, out_isReady 0, out_isLast 0, busy 0.
REQ-030 Reset mid-burst abandons the burst; no partial completion or isLast is emitted; after release arbitration restarts from IDLE.
REQ-031 Reset release takes effect on the first rising clk edge after rst goes high; no transfer in that edge's preceding cycle.

Configuration
REQ-032 Macro BUS_ARBITER_ROUNDROBIN_EN defined: round-robin; search starts at pointer+1 modulo NUM_REQ; pointer set to winner on each grant.
REQ-033 Macro BUS_ARBITER_ROUNDROBIN_EN undefined: fixed priority, lowest index wins; pointer logic absent.

Verification
REQ-034 Single: req[2]=1, numSteps=3, out_canReceive=1, in_isReady[2] each cycle -> req_start=0100 one cycle, 3 words forwarded, isLast on 3rd, busy 3 cycles, owner=2.
REQ-035 Contention RR: req=1111 held, numSteps=1 each -> grant order 0,1,2,3,0 with one idle cycle between bursts; fixed-priority build -> 0,0,0...
REQ-036 Backpressure: numSteps=4, out_canReceive toggles 1,0,0,1,... -> exactly 4 transfers, in_canReceive follows out_canReceive, counter frozen while 0.
REQ-037 Zero length: req[1]=1, numSteps=0 -> req_start[1] pulse, busy stays 0, no out_isReady; next req[3] granted following cycle.
REQ-038 Reset mid-burst: numSteps=5, rst low after 2 words -> all outputs 0 immediately, no isLast; after release req[0] numSteps=1 completes normally with owner=0.
